if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage that sits directly upstream of the CPU decode stage and drives the instruction ROM port (`rom_addr_o`, `rom_ce_o`, `rom_data_i`). It keeps the program counter and issues one combinational ROM read per cycle. Fetched words go into a small prefetch FIFO, and the block presents them to decode with a valid/ready handshake. Jump/branch redirects from execute flush the FIFO and restart fetch at the target.

## Interface
Parameters:
- `ADDR_W`, 32, PC / ROM address width
- `INST_W`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 2, prefetch entries (power of two, ≥2)

Ports:
- `clk_in`  in  1  clock; all state on rising edge
- `rst_in`  in  1  reset, asynchronous, active-high
- `rom_addr_o`  out  ADDR_W  ROM read address (= PC register)
- `rom_ce_o`  out  1  ROM chip enable; read accepted this cycle when high
- `rom_data_i`  in  INST_W  ROM data, combinational from `rom_addr_o`, same cycle
- `jump_i`  in  1  redirect request from execute
- `jump_addr_i`  in  ADDR_W  redirect target
- `id_ready_i`  in  1  decode accepts head entry this cycle
- `if_valid_o`  out  1  head entry valid
- `if_pc_o`  out  ADDR_W  PC of head entry
- `if_inst_o`  out  INST_W  instruction of head entry
- `misalign_o`  out  1  misaligned-target fault (macro-dependent)

## Operation
- State: `pc`, FIFO of {pc, inst} with `count` (0..FIFO_DEPTH), wrap-around read/write pointers, FSM {RUN, HALT}.
- `pop` = `if_valid_o & id_ready_i`. `push` = `rom_ce_o`.
- `rom_ce_o` = RUN & !`rst_in` & !`jump_i` & (`count` < FIFO_DEPTH | `pop`). It depends combinationally on `id_ready_i`, so a full FIFO with a pop refetches in the same cycle.
- On push: write {`pc`, `rom_data_i`} at wptr, `pc` <= `pc` + 4 (mod 2^ADDR_W; wraps silently).
- `count` updates: +1 on push only, −1 on pop only, unchanged on push and pop together.
- `if_valid_o` = (`count` != 0). When invalid, `if_pc_o` = 0 and `if_inst_o` = 32'h0000_0013 (NOP).
- Jump handling (highest priority over push/pop):
  - `jump_i` high: FIFO flushed (`count` <= 0, pointers <= 0), `pc` <= target, no ROM read, and the head is discarded even if `id_ready_i` is high.
  - Execute owns squashing anything decode already took.
- FSM:
  - RUN → HALT only via the misalign rule (Configuration).
  - HALT → RUN on aligned `jump_i`.
  - In HALT: no fetch, and FIFO stays empty.

## Timing
- Reset values while `rst_in` high: `pc`=RESET_PC, `count`=0, FSM=RUN, `rom_ce_o`=0, `rom_addr_o`=RESET_PC, `if_valid_o`=0, `if_pc_o`=0, `if_inst_o`=NOP, `misalign_o`=0.
- First cycle after release: `rom_ce_o`=1, addr=RESET_PC. Next cycle: `if_valid_o`=1, `if_pc_o`=RESET_PC. Fetch-to-valid latency is 1 cycle.
- Steady state with `id_ready_i`=1: one instruction per cycle, no bubbles.
- Jump asserted in cycle N: the ROM read at the target occurs in N+1, and the target becomes valid at the output in N+2. Redirect penalty is 2 cycles.
- Jump and full FIFO in the same cycle: jump wins and the FIFO is empty in N+1.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous), and in-flight entries are lost.

## Configuration
Macro `IF_ALIGN_CHECK_EN`:
- Defined: `jump_i` with `jump_addr_i[1:0]` != 0 sets FSM to HALT, and `misalign_o` <= 1 (registered, sticky). The latched `pc` <= the faulting target, so `rom_addr_o` shows it. `misalign_o` clears on the next aligned jump or on reset.
- Undefined:
  - Target low two bits are forced to 0.
  - HALT is unreachable.
  - `misalign_o` is tied 0.

## Test plan
- Reset release, ROM word at addr N = N, `id_ready_i`=1 → `if_pc_o` 0,4,8,… from cycle 1, `if_inst_o` matching, `if_valid_o` continuously 1.
- `id_ready_i`=0 for 5 cycles → `count` saturates at 2 and `rom_ce_o`=0 after 2 cycles. Head holds pc 0. On release, the outputs are pcs 0,4,8 with no drop and no duplicate.
- `jump_i` with target 0x100 while the FIFO is full → next cycle `if_valid_o`=0 and `rom_addr_o`=0x100. The cycle after: `if_pc_o`=0x100.
- PC wrap: RESET_PC=32'hFFFF_FFFC → outputs FFFF_FFFC, then 0000_0000.
- With `IF_ALIGN_CHECK_EN`: jump to 0x102 → `misalign_o`=1 and `rom_ce_o`=0 held. Jump to 0x200 → `misalign_o`=0, fetch resumes, and 0x200 is valid 2 cycles later. Without the macro, the same jump to 0x102 fetches 0x100.
- Async `rst_in` pulse mid-stream (non-edge-aligned) → outputs return to reset values before the next edge, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, combinational ROM read, prefetch FIFO and valid/ready output to decode.
// Optional macro IF_ALIGN_CHECK_EN: misaligned jump targets halt fetch and raise a sticky misalign_o.
module if_fetch #(
    parameter int               ADDR_W     = 32,
    parameter int               INST_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_ce_o,
    input  logic [INST_W-1:0] rom_data_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              id_ready_i,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              misalign_o,
    output logic              dbg_state_o
);

    // Handshake: decode takes the head entry in any cycle where if_valid_o and id_ready_i are both high.

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [ADDR_W-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [INST_W-1:0] r_fifo_inst [FIFO_DEPTH];

    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_misaligned;
    logic [ADDR_W-1:0] w_target;

`ifdef IF_ALIGN_CHECK_EN
    assign w_target     = jump_addr_i;
    assign w_misaligned = |jump_addr_i[1:0];
`else
    assign w_target     = jump_addr_i & ~ADDR_W'(3);
    assign w_misaligned = 1'b0;
`endif

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & id_ready_i;
    // A full FIFO that is popping this cycle can still accept the new word.
    assign w_push  = (r_state == ST_RUN) & ~rst_in & ~jump_i &
                     ((r_count < CNT_W'(FIFO_DEPTH)) | w_pop);

    assign rom_ce_o    = w_push;
    assign rom_addr_o  = r_pc;
    assign if_valid_o  = w_valid;
    assign if_pc_o     = w_valid ? r_fifo_pc[r_rptr]   : '0;
    assign if_inst_o   = w_valid ? r_fifo_inst[r_rptr] : NOP;
    assign dbg_state_o = r_state;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (jump_i) begin
            w_state_next = w_misaligned ? ST_HALT : ST_RUN;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_pc    <= RESET_PC;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else if (jump_i) begin
            // Redirect discards everything in flight, including a head decode is accepting now.
            r_pc    <= w_target;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) begin
                r_pc   <= r_pc + ADDR_W'(4);
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_fifo_pc[r_wptr]   <= r_pc;
            r_fifo_inst[r_wptr] <= rom_data_i;
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    logic r_misalign;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_misalign <= 1'b0;
        end else if (jump_i) begin
            r_misalign <= w_misaligned;
        end
    end

    assign misalign_o = r_misalign;
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: streaming, stall/backpressure, redirect, PC wrap, misaligned jump, async reset.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] rom_addr;
  logic        rom_ce;
  logic [31:0] rom_data;
  logic        jump;
  logic [31:0] jump_addr;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        misalign;
  logic        dbg_state;

  logic [31:0] w_rom_addr;
  logic        w_rom_ce;
  logic [31:0] w_rom_data;
  logic        w_if_valid;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_inst;
  logic        w_misalign;
  logic        w_dbg_state;

  int total = 0;
  int bad = 0;

  // ROM model: the word stored at address N is N.
  assign rom_data   = rom_addr;
  assign w_rom_data = w_rom_addr;

  if_fetch dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .rom_addr_o  (rom_addr),
    .rom_ce_o    (rom_ce),
    .rom_data_i  (rom_data),
    .jump_i      (jump),
    .jump_addr_i (jump_addr),
    .id_ready_i  (id_ready),
    .if_valid_o  (if_valid),
    .if_pc_o     (if_pc),
    .if_inst_o   (if_inst),
    .misalign_o  (misalign),
    .dbg_state_o (dbg_state)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk_in      (clk),
    .rst_in      (rst),
    .rom_addr_o  (w_rom_addr),
    .rom_ce_o    (w_rom_ce),
    .rom_data_i  (w_rom_data),
    .jump_i      (1'b0),
    .jump_addr_i (32'h0),
    .id_ready_i  (1'b1),
    .if_valid_o  (w_if_valid),
    .if_pc_o     (w_if_pc),
    .if_inst_o   (w_if_inst),
    .misalign_o  (w_misalign),
    .dbg_state_o (w_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ce"},    {31'h0, rom_ce},   32'h0);
    chk({tag, "_addr"},  rom_addr,          32'h0);
    chk({tag, "_valid"}, {31'h0, if_valid}, 32'h0);
    chk({tag, "_pc"},    if_pc,             32'h0);
    chk({tag, "_inst"},  if_inst,           32'h0000_0013);
    chk({tag, "_mis"},   {31'h0, misalign}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    jump = 1'b0;
    jump_addr = 32'h0;
    id_ready = 1'b1;
    #2;
    chk_reset_vals("rst0");
    chk("w_rst_addr", w_rom_addr, 32'hFFFF_FFFC);

    // Release reset; first cycle fetches RESET_PC with nothing valid yet.
    tick();
    rst = 1'b0;
    #1;
    chk("c0_ce", {31'h0, rom_ce}, 32'h1);
    chk("c0_addr", rom_addr, 32'h0);
    chk("c0_valid", {31'h0, if_valid}, 32'h0);
    chk("w_c0_addr", w_rom_addr, 32'hFFFF_FFFC);

    // Streaming with decode always ready.
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("str_valid", {31'h0, if_valid}, 32'h1);
      chk("str_pc", if_pc, 32'(4 * k));
      chk("str_inst", if_inst, 32'(4 * k));
      chk("str_addr", rom_addr, 32'(4 * k + 4));
      if (k == 0) begin
        chk("wrap_pc0", w_if_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", w_rom_addr, 32'h0);
      end else if (k == 1) begin
        chk("wrap_pc1", w_if_pc, 32'h0);
        chk("wrap_valid", {31'h0, w_if_valid}, 32'h1);
      end
      tick();
    end

    // Stall: head 16, pc 20, one entry. FIFO fills, then fetch stops.
    id_ready = 1'b0;
    #1;
    chk("stall1_ce", {31'h0, rom_ce}, 32'h1);
    tick();
    for (int s = 0; s < 4; s++) begin
      #1;
      chk("stall_ce", {31'h0, rom_ce}, 32'h0);
      chk("stall_pc", if_pc, 32'h10);
      chk("stall_addr", rom_addr, 32'h18);
      tick();
    end

    // Release: full FIFO with pop refetches in the same cycle.
    id_ready = 1'b1;
    #1;
    chk("rel_ce", {31'h0, rom_ce}, 32'h1);
    chk("rel_pc0", if_pc, 32'h10);
    tick();
    #1;
    chk("rel_pc1", if_pc, 32'h14);
    tick();
    #1;
    chk("rel_pc2", if_pc, 32'h18);
    chk("rel_addr", rom_addr, 32'h20);

    // Jump while full: no read this cycle, target read next cycle, valid the one after.
    jump = 1'b1;
    jump_addr = 32'h100;
    #1;
    chk("jmp_ce", {31'h0, rom_ce}, 32'h0);
    tick();
    jump = 1'b0;
    #1;
    chk("jmp1_valid", {31'h0, if_valid}, 32'h0);
    chk("jmp1_addr", rom_addr, 32'h100);
    chk("jmp1_ce", {31'h0, rom_ce}, 32'h1);
    chk("jmp1_inst", if_inst, 32'h0000_0013);
    tick();
    #1;
    chk("jmp2_valid", {31'h0, if_valid}, 32'h1);
    chk("jmp2_pc", if_pc, 32'h100);
    chk("jmp2_inst", if_inst, 32'h100);

    // Misaligned target.
    jump = 1'b1;
    jump_addr = 32'h102;
    tick();
    jump = 1'b0;
    #1;
`ifdef IF_ALIGN_CHECK_EN
    chk("mis_flag", {31'h0, misalign}, 32'h1);
    chk("mis_ce", {31'h0, rom_ce}, 32'h0);
    chk("mis_addr", rom_addr, 32'h102);
    tick();
    #1;
    chk("mis_hold_flag", {31'h0, misalign}, 32'h1);
    chk("mis_hold_ce", {31'h0, rom_ce}, 32'h0);
    chk("mis_hold_valid", {31'h0, if_valid}, 32'h0);
`else
    chk("mis_flag", {31'h0, misalign}, 32'h0);
    chk("mis_addr", rom_addr, 32'h100);
    chk("mis_ce", {31'h0, rom_ce}, 32'h1);
    tick();
    #1;
    chk("mis_pc", if_pc, 32'h100);
`endif

    // Aligned jump resumes fetch.
    jump = 1'b1;
    jump_addr = 32'h200;
    tick();
    jump = 1'b0;
    #1;
    chk("al_flag", {31'h0, misalign}, 32'h0);
    chk("al_addr", rom_addr, 32'h200);
    chk("al_ce", {31'h0, rom_ce}, 32'h1);
    tick();
    #1;
    chk("al_pc", if_pc, 32'h200);
    chk("al_valid", {31'h0, if_valid}, 32'h1);
    tick();
    tick();

    // Async reset pulse between edges.
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    tick();
    rst = 1'b0;
    #1;
    chk("arst_c0_ce", {31'h0, rom_ce}, 32'h1);
    chk("arst_c0_addr", rom_addr, 32'h0);
    tick();
    #1;
    chk("arst_c1_valid", {31'h0, if_valid}, 32'h1);
    chk("arst_c1_pc", if_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
